// File: rtl/bht_stats_pkg.sv
// Purpose: shared register map, CTRL bit positions and responder states for bht_stats_mmio.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: byte offsets of the window registers, CTRL bit indices, resp_state_t.
package bht_stats_pkg;

   // Byte offsets inside the 32-byte window (address bits [1:0] are ignored by the decoder)
   localparam logic [4:0] CTRL_OFS = 5'h00;
   localparam logic [4:0] PRED_OFS = 5'h04;
   localparam logic [4:0] MISP_OFS = 5'h08;
   localparam logic [4:0] CORR_OFS = 5'h0C;
   localparam logic [4:0] CYC_OFS  = 5'h10;

   // CTRL write bits
   localparam int SNAP_BIT = 0;
   localparam int CLR_BIT  = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } resp_state_t;

endpackage

// File: rtl/bht_stats_mmio_perf_ctr.sv
// Purpose: one wrapping event counter with synchronous clear and a wrap pulse.
// Latency: count visible the cycle after i_inc; o_wrap is combinational in the wrapping cycle.
// Backpressure: none, counts every qualified cycle.
// Ports: clk, rst_n | i_inc (count this cycle), i_clr (zero, wins over i_inc) | o_cnt, o_wrap.
module perf_ctr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt,
   output logic         o_wrap
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   // A wrap suppressed by clear must not re-arm the overflow flag that clear is resetting
   assign o_wrap = i_inc & ~i_clr & (&r_cnt);

endmodule

// File: rtl/bht_stats_mmio.sv
// Purpose: memory-mapped branch-predictor statistics (live counters, atomic snapshot, clear).
// Latency: mem_resp exactly 1 cycle after a hit request is sampled; one request per 2 cycles.
// Backpressure: master holds mem_read/mem_write until mem_resp; requests during RESP are ignored.
// Ports: clk, rst_n | pred_event, mispredict (event inputs) |
//        mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable (request) |
//        mem_rdata, mem_resp (completion).
module bht_stats_mmio
   import bht_stats_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
   parameter int          CTR_W     = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_event,
   input  logic        mispredict,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_rdata,
   output logic        mem_resp
);

   resp_state_t r_state;
   resp_state_t w_state_nxt;

   logic [CTR_W-1:0] w_pred_cnt, w_misp_cnt, w_cyc_cnt;
   logic             w_pred_wrap, w_misp_wrap, w_cyc_wrap;

   logic [CTR_W-1:0] r_snap_pred, r_snap_misp, r_snap_cyc;
   logic             r_snap_vld;
   logic             r_ovf;
   logic [31:0]      r_rdata;

   logic        w_hit, w_accept, w_wr, w_ctrl_wr, w_snap, w_clr;
   logic [4:0]  w_ofs;
   logic [31:0] w_rd_val;
   logic [CTR_W-1:0] w_snap_corr;

   // Address bits that the decoder intentionally ignores
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, mem_address[1:0], mem_wdata[31:2], mem_byte_enable[3:1]};

   // ---------------- request decode ----------------
   assign w_hit     = (mem_address[31:5] == BASE_ADDR[31:5]);
   assign w_accept  = (r_state == IDLE) & (mem_read | mem_write) & w_hit;
   // read+write together is treated as a write
   assign w_wr      = w_accept & mem_write;
   assign w_ofs     = {mem_address[4:2], 2'b00};
   assign w_ctrl_wr = w_wr & (w_ofs == CTRL_OFS) & mem_byte_enable[0];
   assign w_snap    = w_ctrl_wr & mem_wdata[SNAP_BIT];
   assign w_clr     = w_ctrl_wr & mem_wdata[CLR_BIT];

   // ---------------- live counters ----------------
   perf_ctr #(.W(CTR_W)) u_pred_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (pred_event),
      .i_clr  (w_clr),
      .o_cnt  (w_pred_cnt),
      .o_wrap (w_pred_wrap)
   );

   perf_ctr #(.W(CTR_W)) u_misp_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (mispredict),
      .i_clr  (w_clr),
      .o_cnt  (w_misp_cnt),
      .o_wrap (w_misp_wrap)
   );

   perf_ctr #(.W(CTR_W)) u_cyc_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (1'b1),
      .i_clr  (w_clr),
      .o_cnt  (w_cyc_cnt),
      .o_wrap (w_cyc_wrap)
   );

   // ---------------- snapshot / status ----------------
   // Snapshot reads the pre-edge counter values, so a same-cycle event counts live only,
   // and a combined snapshot+clear captures the values before they are zeroed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap_pred <= '0;
         r_snap_misp <= '0;
         r_snap_cyc  <= '0;
      end else if (w_snap) begin
         r_snap_pred <= w_pred_cnt;
         r_snap_misp <= w_misp_cnt;
         r_snap_cyc  <= w_cyc_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap_vld <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         // snapshot+clear leaves a valid snapshot behind
         if (w_snap) begin
            r_snap_vld <= 1'b1;
         end else if (w_clr) begin
            r_snap_vld <= 1'b0;
         end

         if (w_clr) begin
            r_ovf <= 1'b0;
         end else if (w_pred_wrap | w_misp_wrap | w_cyc_wrap) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // ---------------- read mux ----------------
   assign w_snap_corr = r_snap_pred - r_snap_misp;

   always_comb begin
      w_rd_val = '0;
      if (!mem_write) begin
         unique case (w_ofs)
            CTRL_OFS: w_rd_val = {30'd0, r_ovf, r_snap_vld};
            PRED_OFS: w_rd_val = 32'(r_snap_pred);
            MISP_OFS: w_rd_val = 32'(r_snap_misp);
            CORR_OFS: w_rd_val = 32'(w_snap_corr);
            CYC_OFS:  w_rd_val = 32'(r_snap_cyc);
            default:  w_rd_val = '0;
         endcase
      end
   end

   // Load data is captured at the accepting edge and held until the next accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (w_accept) begin
         r_rdata <= w_rd_val;
      end
   end

   assign mem_rdata = r_rdata;

   // ---------------- responder FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_resp    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            mem_resp    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bht_stats_mmio.sv
module tb_bht_stats_mmio;

   localparam logic [31:0] BASE = 32'hFFFF_F000;

   logic        clk;
   logic        rst_n;
   logic        pred_event, mispredict, s_pred_event;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata, s_rdata;
   logic        mem_resp, s_resp;

   int vectors;
   int miscompares;

   bht_stats_mmio #(.BASE_ADDR(BASE), .CTR_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pred_event      (pred_event),
      .mispredict      (mispredict),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp)
   );

   // Narrow instance sharing the bus, used for wrap/overflow behaviour
   bht_stats_mmio #(.BASE_ADDR(BASE), .CTR_W(4)) dut_s (
      .clk             (clk),
      .rst_n           (rst_n),
      .pred_event      (s_pred_event),
      .mispredict      (1'b0),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (s_rdata),
      .mem_resp        (s_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model of the 32-bit instance ----------------
   logic [31:0] m_pred, m_misp, m_cyc, m_spred, m_smisp, m_scyc, m_rdata;
   bit          m_vld, m_ovf, m_resp;
   bit          t_acc, t_snap, t_clr, t_wrap;
   logic [31:0] t_rv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pred <= 0; m_misp <= 0; m_cyc <= 0;
         m_spred <= 0; m_smisp <= 0; m_scyc <= 0;
         m_vld <= 0; m_ovf <= 0; m_resp <= 0; m_rdata <= 0;
      end else begin
         t_acc  = !m_resp && (mem_read || mem_write) && (mem_address[31:5] == BASE[31:5]);
         t_snap = t_acc && mem_write && (mem_address[4:2] == 3'd0) && mem_byte_enable[0] && mem_wdata[0];
         t_clr  = t_acc && mem_write && (mem_address[4:2] == 3'd0) && mem_byte_enable[0] && mem_wdata[1];
         case (mem_address[4:2])
            3'd0:    t_rv = {30'd0, m_ovf, m_vld};
            3'd1:    t_rv = m_spred;
            3'd2:    t_rv = m_smisp;
            3'd3:    t_rv = m_spred - m_smisp;
            3'd4:    t_rv = m_scyc;
            default: t_rv = 0;
         endcase
         if (mem_write) t_rv = 0;
         m_resp <= t_acc;
         if (t_acc) m_rdata <= t_rv;
         if (t_snap) begin
            m_spred <= m_pred; m_smisp <= m_misp; m_scyc <= m_cyc; m_vld <= 1;
         end else if (t_clr) begin
            m_vld <= 0;
         end
         t_wrap = (pred_event && m_pred == 32'hFFFF_FFFF) || (mispredict && m_misp == 32'hFFFF_FFFF)
                  || (m_cyc == 32'hFFFF_FFFF);
         if (t_clr) begin
            m_pred <= 0; m_misp <= 0; m_cyc <= 0; m_ovf <= 0;
         end else begin
            m_pred <= m_pred + (pred_event ? 32'd1 : 32'd0);
            m_misp <= m_misp + (mispredict ? 32'd1 : 32'd0);
            m_cyc  <= m_cyc + 32'd1;
            if (t_wrap) m_ovf <= 1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         chk("cyc_resp", {31'd0, mem_resp}, {31'd0, m_resp});
         chk("cyc_rdata", mem_rdata, m_rdata);
      end
   endtask

   // ---------------- stimulus helpers (start/end at posedge+2) ----------------
   task automatic cycle(input bit pe, input bit mp, input bit spe);
      pred_event = pe; mispredict = mp; s_pred_event = spe;
      @(posedge clk); #2;
      pred_event = 0; mispredict = 0; s_pred_event = 0;
   endtask

   task automatic bus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input bit pe,
                      output logic [31:0] rdat, output logic [31:0] rdat_s);
      mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
      pred_event = pe;
      @(posedge clk); #2;
      pred_event = 0;
      chk("resp_latency", {31'd0, mem_resp}, 32'd1);
      rdat = mem_rdata; rdat_s = s_rdata;
      mem_read = 0; mem_write = 0;
      @(posedge clk); #2;
   endtask

   task automatic wr_ctrl(input logic [31:0] v, input bit pe);
      logic [31:0] a, b;
      bus(0, 1, BASE, v, 4'hF, pe, a, b);
   endtask

   task automatic rd_reg(input logic [4:0] ofs, output logic [31:0] v, output logic [31:0] vs);
      bus(1, 0, BASE + {27'd0, ofs}, 32'd0, 4'h0, 0, v, vs);
   endtask

   logic [31:0] rv, rvs;
   int          resp_seen;

   initial begin
      vectors = 0; miscompares = 0;
      rst_n = 0; pred_event = 0; mispredict = 0; s_pred_event = 0;
      mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0; mem_byte_enable = 0;
      fork
         compare_loop();
      join_none
      repeat (3) @(posedge clk);
      #2;
      chk("reset_resp", {31'd0, mem_resp}, 32'd0);
      chk("reset_rdata", mem_rdata, 32'd0);
      rst_n = 1;
      @(posedge clk); #2;

      // 10 predictions, 3 of them mispredicted, then snapshot
      for (int i = 0; i < 10; i++) cycle(1, i < 3, 0);
      wr_ctrl(32'h1, 0);
      rd_reg(5'h04, rv, rvs); chk("snap_pred_10", rv, 32'd10);
      rd_reg(5'h08, rv, rvs); chk("snap_misp_3", rv, 32'd3);
      rd_reg(5'h0C, rv, rvs); chk("snap_corr_7", rv, 32'd7);
      rd_reg(5'h00, rv, rvs); chk("status_vld", rv, 32'h1);
      rd_reg(5'h11, rv, rvs); // byte lanes [1:0] ignored: still SNAP_CYCLES
      bus(0, 1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 0, rv, rvs); // reserved write, acked

      // event in the snapshot cycle is counted live, not in the snapshot
      wr_ctrl(32'h2, 0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0);
      wr_ctrl(32'h1, 1);
      rd_reg(5'h04, rv, rvs); chk("snap_same_cycle_5", rv, 32'd5);
      wr_ctrl(32'h1, 0);
      rd_reg(5'h04, rv, rvs); chk("snap_again_6", rv, 32'd6);

      // read-and-reset
      wr_ctrl(32'h2, 0);
      for (int i = 0; i < 20; i++) cycle(1, i < 4, 0);
      wr_ctrl(32'h3, 0);
      rd_reg(5'h04, rv, rvs); chk("rr_pred_20", rv, 32'd20);
      rd_reg(5'h08, rv, rvs); chk("rr_misp_4", rv, 32'd4);
      rd_reg(5'h00, rv, rvs); chk("rr_status", rv, 32'h1);
      wr_ctrl(32'h1, 0);
      rd_reg(5'h04, rv, rvs); chk("rr_after_0", rv, 32'd0);

      // 4-bit instance: 17 events wrap to 1 and raise overflow
      wr_ctrl(32'h2, 0);
      for (int i = 0; i < 17; i++) cycle(0, 0, 1);
      wr_ctrl(32'h1, 0);
      rd_reg(5'h04, rv, rvs); chk("w4_snap_pred_1", rvs, 32'd1);
      rd_reg(5'h00, rv, rvs); chk("w4_status_3", rvs, 32'h3);

      // outside window: no response
      mem_read = 1; mem_address = BASE + 32'h40; resp_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (mem_resp) resp_seen++;
      end
      mem_read = 0;
      chk("miss_no_resp", resp_seen, 32'd0);
      rd_reg(5'h18, rv, rvs); chk("reserved_rd_0", rv, 32'd0);
      wr_ctrl(32'h2, 0);
      bus(0, 1, BASE, 32'h1, 4'b1110, 0, rv, rvs);
      rd_reg(5'h00, rv, rvs); chk("be0_clear_ignored", rv, 32'h0);

      // reset during RESP aborts the response
      wr_ctrl(32'h1, 0);
      mem_read = 1; mem_address = BASE;
      @(posedge clk); #2;
      mem_read = 0;
      chk("in_resp_before_rst", {31'd0, mem_resp}, 32'd1);
      rst_n = 0;
      #1;
      chk("rst_abort_resp", {31'd0, mem_resp}, 32'd0);
      chk("rst_abort_rdata", mem_rdata, 32'd0);
      @(posedge clk); #2;
      rst_n = 1;
      @(posedge clk); #2;
      rd_reg(5'h00, rv, rvs); chk("post_rst_status", rv, 32'h0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bht_stats_mmio.md
Name: bht_stats_mmio

Overview:
- Read-side responder for branch-predictor statistics: counts prediction and misprediction events and serves them to software as memory-mapped registers.
- Sits on the data-memory path beside the arbiter and claims a fixed 32-byte window. CPU loads read snapshot registers; CPU stores trigger a snapshot or a clear.
- A snapshot gives software an atomic, mutually consistent set of counters.

Parameters:
- BASE_ADDR, 32'hFFFF_F000, window base; must be 32-byte aligned.
- CTR_W, 32, width of every counter and snapshot register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pred_event  in  1  one branch/jump resolved in EX this cycle (idex jump or branch).
- mispredict  in  1  a misprediction is flushed this cycle.
- mem_read  in  1  load request; held by master until mem_resp.
- mem_write  in  1  store request; held by master until mem_resp.
- mem_address  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_byte_enable  in  4  store byte lanes.
- mem_rdata  out  32  load data; valid when mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.

Behaviour:
- Hit: mem_address[31:5] == BASE_ADDR[31:5]. Requests that miss the window are ignored and get no mem_resp.
- Register map (word offsets; address bits [1:0] ignored):
  - 0x00 CTRL/STATUS
  - 0x04 SNAP_PRED
  - 0x08 SNAP_MISP
  - 0x0C SNAP_CORRECT (= SNAP_PRED - SNAP_MISP, mod 2^CTR_W)
  - 0x10 SNAP_CYCLES
  - 0x14-0x1C read 0; writes there are ignored but still acknowledged.
- STATUS read value:
  - bit0 snap_valid: set by a snapshot, cleared by clear.
  - bit1 overflow: sticky; set when any live counter wraps from all-ones to 0; cleared by clear.
  - bits [31:2] read 0.
- CTRL write (acted on only when mem_byte_enable[0]=1):
  - wdata bit0 = snapshot.
  - wdata bit1 = clear.
  - Both bits set: snapshot captures the pre-clear values, then clear takes effect (read-and-reset).
- Live counters: pred_ctr (+1 per pred_event cycle), misp_ctr (+1 per mispredict cycle, independent of pred_event), cyc_ctr (+1 every cycle). All wrap modulo 2^CTR_W.
- Clear zeroes all three live counters and overflow at the edge ending the write's IDLE cycle.
  - An event arriving in that same cycle is dropped (clear wins).
  - Snapshot registers are untouched by clear.
- Snapshot copies the live counter values present before that edge's increments, so an event in the same cycle is excluded from the snapshot but counted live.
- Responder FSM, two states:
  - IDLE: a hit request is sampled. Its write side effects apply at this edge; read data is latched at this edge. Go to RESP.
  - RESP: mem_resp=1 and mem_rdata shows the latched value; new requests are ignored. Return to IDLE unconditionally.
  - Latency is exactly 1 cycle from request sample to resp. Back-to-back requests are accepted every 2 cycles.
- mem_read and mem_write both set: treat as a write; mem_rdata returns 0.
- Reset (async assert, synchronous release):
  - All counters, snapshots and flags = 0.
  - FSM = IDLE, mem_resp = 0, mem_rdata = 0.
  - Reset during RESP aborts the response; no resp pulse occurs.
- mem_rdata holds its last value outside RESP.

Decomposition:
- Shared package bht_stats_pkg holds:
  - register offset localparams (CTRL_OFS … CYC_OFS) and CTRL bit indices (SNAP_BIT=0, CLR_BIT=1);
  - enum resp_state_t {IDLE, RESP}.
- Sub-module: perf_ctr, one CTR_W counter with inc, clr and a wrap pulse output. Instantiated three times; the top ORs the wrap pulses into the sticky overflow.

Test Plan:
- Reset release, then 10 pred_event cycles and 3 mispredict cycles; write CTRL=0x1 → SNAP_PRED=10, SNAP_MISP=3, SNAP_CORRECT=7, STATUS=0x1. Each mem_resp arrives exactly 1 cycle after the request.
- pred_event high in the same cycle the CTRL=0x1 write is sampled (live count 5) → SNAP_PRED=5. A second snapshot with no further events gives 6.
- Write CTRL=0x3 with live pred=20, misp=4 → SNAP_PRED=20, SNAP_MISP=4. STATUS reads 0x1 (overflow cleared). A further snapshot gives SNAP_PRED=0.
- With CTR_W=4, apply 17 pred_event cycles, then snapshot → SNAP_PRED=1, STATUS=0x3.
- Load to BASE_ADDR+0x40 (outside window) → no mem_resp within 20 cycles. Load to BASE_ADDR+0x18 → mem_rdata=0 with resp. Store with byte_enable=4'b1110 and wdata=0x1 → snap_valid unchanged.
- Drop rst_n low while in RESP → mem_resp=0 immediately. After release, a read of STATUS returns 0x0.
